// File: rtl/cmp_pkg.sv
// Shared types and helpers for the serial magnitude comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One-hot result encoding, bit order {gr, ls, eq}
  localparam logic [2:0] RES_GR = 3'b100;
  localparam logic [2:0] RES_LS = 3'b010;
  localparam logic [2:0] RES_EQ = 3'b001;

  // Ceiling log2, evaluated at elaboration for counter/index widths
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational compare of one operand chunk; flip_msb_i turns the
// two's-complement sign bit into offset binary so an unsigned compare works.
module cmp_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             flip_msb_i,
  output logic             gt_o,
  output logic             lt_o
);

  logic [CHUNK-1:0] a_x;
  logic [CHUNK-1:0] b_x;

  // Optional sign-bit inversion followed by a plain unsigned compare
  always_comb begin
    a_x            = a_i;
    b_x            = b_i;
    a_x[CHUNK-1]   = a_i[CHUNK-1] ^ flip_msb_i;
    b_x[CHUNK-1]   = b_i[CHUNK-1] ^ flip_msb_i;
    gt_o           = (a_x > b_x);
    lt_o           = (a_x < b_x);
  end

endmodule

// File: rtl/cmp_serial_mag.sv
// Multi-cycle magnitude comparator: one operand pair per handshake, compared
// CHUNK bits per cycle MSB first with early exit, plus saturating counters
// of delivered gr/ls/eq results.
module cmp_serial_mag
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gr,
  output logic             ls,
  output logic             eq,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_gr,
  output logic [CNT_W-1:0] cnt_ls,
  output logic [CNT_W-1:0] cnt_eq
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int IDX_W = (clog2(NCH) < 1) ? 1 : clog2(NCH);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    return (en && (v != CNT_MAX)) ? v + 1'b1 : v;
  endfunction

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [2:0]                  res_q, res_d;
  logic                        vld_q, vld_d;
  logic [NCH-1:0][CHUNK-1:0]   a_q, b_q;
  logic                        sgn_q;
  logic [CNT_W-1:0]            cnt_gr_q, cnt_gr_d;
  logic [CNT_W-1:0]            cnt_ls_q, cnt_ls_d;
  logic [CNT_W-1:0]            cnt_eq_q, cnt_eq_d;
  logic                        accept, deliver;
  logic                        ch_gt, ch_lt, ch_eq;

  assign in_ready  = (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign deliver   = vld_q && out_ready;
  assign out_valid = vld_q;
  assign gr        = res_q[2];
  assign ls        = res_q[1];
  assign eq        = res_q[0];
  assign cnt_gr    = cnt_gr_q;
  assign cnt_ls    = cnt_ls_q;
  assign cnt_eq    = cnt_eq_q;
  assign ch_eq     = ~ch_gt & ~ch_lt;

  // Sign flip only applies to the chunk holding the operand MSB
  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i        (a_q[idx_q]),
    .b_i        (b_q[idx_q]),
    .flip_msb_i (sgn_q && (idx_q == IDX_TOP)),
    .gt_o       (ch_gt),
    .lt_o       (ch_lt)
  );

  // Operand capture on accept; data path needs no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= a;
      b_q   <= b;
      sgn_q <= signed_mode;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      res_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
    end
  end

  // Next-state: walk chunks MSB first, stop at the first difference
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    res_d   = res_q;
    vld_d   = vld_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          idx_d   = IDX_TOP;
        end
      end
      RUN: begin
        if (ch_gt) begin
          res_d   = RES_GR;
          vld_d   = 1'b1;
          state_d = DONE;
        end else if (ch_lt) begin
          res_d   = RES_LS;
          vld_d   = 1'b1;
          state_d = DONE;
        end else if (ch_eq && (idx_q == '0)) begin
          res_d   = RES_EQ;
          vld_d   = 1'b1;
          state_d = DONE;
        end else begin
          idx_d   = idx_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          res_d   = '0;
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Counter next-state: clear has priority over a same-cycle increment
  always_comb begin
    cnt_gr_d = sat_inc(cnt_gr_q, deliver && (res_q == RES_GR));
    cnt_ls_d = sat_inc(cnt_ls_q, deliver && (res_q == RES_LS));
    cnt_eq_d = sat_inc(cnt_eq_q, deliver && (res_q == RES_EQ));
    if (clr_cnt) begin
      cnt_gr_d = '0;
      cnt_ls_d = '0;
      cnt_eq_d = '0;
    end
  end

  // Event counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_gr_q <= '0;
      cnt_ls_q <= '0;
      cnt_eq_q <= '0;
    end else begin
      cnt_gr_q <= cnt_gr_d;
      cnt_ls_q <= cnt_ls_d;
      cnt_eq_q <= cnt_eq_d;
    end
  end

endmodule

// File: tb/tb_cmp_serial_mag.sv
// Bench for cmp_serial_mag: three instances (CHUNK=1,2,4) share stimulus and
// are checked every cycle against a transaction-level model.
module tb_cmp_serial_mag;

  localparam int W    = 8;
  localparam int CW   = 2;
  localparam int NI   = 3;
  localparam int CMAX = (1 << CW) - 1;
  localparam int CHK [NI] = '{1, 2, 4};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic clr_cnt = 1'b0;
  logic signed_mode = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic [NI-1:0] in_ready, out_valid, gr, ls, eq;
  logic [CW-1:0] cgr [NI];
  logic [CW-1:0] cls [NI];
  logic [CW-1:0] ceq [NI];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cmp_serial_mag #(.WIDTH(W), .CHUNK(1), .CNT_W(CW)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid[0]),
    .out_ready(out_ready), .gr(gr[0]), .ls(ls[0]), .eq(eq[0]),
    .clr_cnt(clr_cnt), .cnt_gr(cgr[0]), .cnt_ls(cls[0]), .cnt_eq(ceq[0]));

  cmp_serial_mag #(.WIDTH(W), .CHUNK(2), .CNT_W(CW)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid[1]),
    .out_ready(out_ready), .gr(gr[1]), .ls(ls[1]), .eq(eq[1]),
    .clr_cnt(clr_cnt), .cnt_gr(cgr[1]), .cnt_ls(cls[1]), .cnt_eq(ceq[1]));

  cmp_serial_mag #(.WIDTH(W), .CHUNK(4), .CNT_W(CW)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
    .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid[2]),
    .out_ready(out_ready), .gr(gr[2]), .ls(ls[2]), .eq(eq[2]),
    .clr_cnt(clr_cnt), .cnt_gr(cgr[2]), .cnt_ls(cls[2]), .cnt_eq(ceq[2]));

  task automatic check(input string nm, input int inst, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s inst=%0d got=%0d want=%0d t=%0t", nm, inst, act, exp, $time);
    end
  endtask

  // Result class: 0 = a>b, 1 = a<b, 2 = equal
  function automatic int exp_res(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
    int ix, iy;
    ix = sm ? int'($signed(x)) : int'(x);
    iy = sm ? int'($signed(y)) : int'(y);
    if (ix > iy) return 0;
    if (ix < iy) return 1;
    return 2;
  endfunction

  // Cycles from accept to result: one per equal leading chunk plus one, capped at NCH
  function automatic int exp_k(input logic [W-1:0] x, input logic [W-1:0] y, input int c);
    int nch, e, d;
    bit stop;
    nch  = W / c;
    e    = 0;
    stop = 1'b0;
    d    = int'(x ^ y);
    for (int i = nch - 1; i >= 0; i--) begin
      if (!stop) begin
        if (((d >> (i * c)) & ((1 << c) - 1)) == 0) e++;
        else stop = 1'b1;
      end
    end
    return (e == nch) ? nch : e + 1;
  endfunction

  // Model state per instance
  bit busy  [NI];
  int since [NI];
  int kk    [NI];
  int res   [NI];
  int mcnt  [NI][3];

  // Transaction-level model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        busy[i]  <= 1'b0;
        since[i] <= 0;
        for (int j = 0; j < 3; j++) mcnt[i][j] <= 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (clr_cnt) begin
          for (int j = 0; j < 3; j++) mcnt[i][j] <= 0;
        end else if (busy[i] && since[i] >= kk[i] && out_ready && mcnt[i][res[i]] < CMAX) begin
          mcnt[i][res[i]] <= mcnt[i][res[i]] + 1;
        end
        if (busy[i] && since[i] >= kk[i] && out_ready) begin
          busy[i] <= 1'b0;
        end else if (!busy[i] && in_valid) begin
          busy[i]  <= 1'b1;
          since[i] <= 0;
          kk[i]    <= exp_k(a, b, CHK[i]);
          res[i]   <= exp_res(a, b, signed_mode);
        end else if (busy[i]) begin
          since[i] <= since[i] + 1;
        end
      end
    end
  end

  // Per-cycle comparison of every instance against the model
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      bit ev;
      ev = busy[i] && (since[i] >= kk[i]);
      check("out_valid", i, int'(out_valid[i]), int'(ev));
      check("in_ready",  i, int'(in_ready[i]),  int'(!busy[i]));
      check("gr",        i, int'(gr[i]),        int'(ev && res[i] == 0));
      check("ls",        i, int'(ls[i]),        int'(ev && res[i] == 1));
      check("eq",        i, int'(eq[i]),        int'(ev && res[i] == 2));
      check("cnt_gr",    i, int'(cgr[i]),       mcnt[i][0]);
      check("cnt_ls",    i, int'(cls[i]),       mcnt[i][1]);
      check("cnt_eq",    i, int'(ceq[i]),       mcnt[i][2]);
    end
  end

  // One full transaction on all instances; returns CHUNK=2 latency and result
  task automatic do_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic sm,
                        input int stall, input bit clr, input bit poke,
                        output int lat, output logic [2:0] r2);
    int g;
    g = 0;
    while (in_ready != 3'b111 && g < 50) begin @(posedge clk); #1; g++; end
    if (g >= 50) check("idle_timeout", 1, 1, 0);
    a = ta; b = tb_v; signed_mode = sm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
    g = 0;
    while (!out_valid[1] && g < 20) begin @(posedge clk); #1; g++; end
    lat = g;
    r2 = {gr[1], ls[1], eq[1]};
    g = 0;
    while (out_valid != 3'b111 && g < 20) begin @(posedge clk); #1; g++; end
    if (g >= 20) check("done_timeout", 0, 1, 0);
    if (poke) in_valid = 1'b1;
    for (int s = 0; s < stall; s++) begin @(posedge clk); #1; end
    if (poke) begin
      check("stall_in_ready", 1, int'(in_ready[1]), 0);
      check("stall_gr_held",  1, int'({gr[1], ls[1], eq[1]}), int'(r2));
    end
    in_valid = 1'b0;
    out_ready = 1'b1; clr_cnt = clr;
    @(posedge clk); #1;
    out_ready = 1'b0; clr_cnt = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [2:0] r;
    logic [W-1:0] ra, rb;
    int g;

    // Model sanity against hand-computed values
    check("model_k_A5", 0, exp_k(8'hA5, 8'hA5, 2), 4);
    check("model_k_1213", 0, exp_k(8'h12, 8'h13, 2), 4);
    check("model_k_1213_c4", 0, exp_k(8'h12, 8'h13, 4), 2);
    check("model_res_signed", 0, exp_res(8'h80, 8'h7F, 1'b1), 1);
    check("model_res_unsigned", 0, exp_res(8'h80, 8'h7F, 1'b0), 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 0, int'(in_ready), 7);
    check("rst_out_valid", 0, int'(out_valid), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Equal operands run all chunks
    do_txn(8'hA5, 8'hA5, 1'b0, 0, 1'b0, 1'b0, lat, r);
    check("t1_lat", 1, lat, 4);
    check("t1_res", 1, int'(r), 3'b001);
    check("t1_cnt_eq", 1, int'(ceq[1]), 1);

    // Sign handling decides in the top chunk
    do_txn(8'h80, 8'h7F, 1'b0, 0, 1'b0, 1'b0, lat, r);
    check("t2u_lat", 1, lat, 1);
    check("t2u_res", 1, int'(r), 3'b100);
    do_txn(8'h80, 8'h7F, 1'b1, 0, 1'b0, 1'b0, lat, r);
    check("t2s_lat", 1, lat, 1);
    check("t2s_res", 1, int'(r), 3'b010);

    // Difference only in the last chunk; negative vs zero
    do_txn(8'h12, 8'h13, 1'b0, 0, 1'b0, 1'b0, lat, r);
    check("t3a_lat", 1, lat, 4);
    check("t3a_res", 1, int'(r), 3'b010);
    do_txn(8'hFF, 8'h00, 1'b1, 0, 1'b0, 1'b0, lat, r);
    check("t3b_lat", 1, lat, 1);
    check("t3b_res", 1, int'(r), 3'b010);
    check("t3_cnt_ls", 1, int'(cls[1]), 3);

    // Consumer stall with a competing input request
    do_txn(8'h03, 8'h01, 1'b0, 5, 1'b0, 1'b1, lat, r);
    check("t4_lat", 1, lat, 4);
    check("t4_res", 1, int'(r), 3'b100);

    // Reset while a comparison is in progress
    g = 0;
    while (in_ready != 3'b111 && g < 50) begin @(posedge clk); #1; g++; end
    a = 8'h12; b = 8'h13; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", 1, int'(out_valid), 0);
    check("t6_in_ready", 1, int'(in_ready), 7);
    check("t6_res", 1, int'({gr[1], ls[1], eq[1]}), 0);
    check("t6_cnt_ls", 1, int'(cls[1]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int s = 0; s < 10; s++) begin
      @(posedge clk); #1;
      check("t6_no_result", 1, int'(out_valid), 0);
    end

    // Saturation and clear priority
    for (int n = 0; n < 4; n++) do_txn(8'hC0, 8'h40, 1'b0, 0, 1'b0, 1'b0, lat, r);
    check("t5_sat", 1, int'(cgr[1]), 3);
    do_txn(8'hC0, 8'h40, 1'b0, 0, 1'b1, 1'b0, lat, r);
    check("t5_clr", 1, int'(cgr[1]), 0);

    // Randomised pairs, both modes, biased toward shared prefixes
    for (int n = 0; n < 1000; n++) begin
      int sel;
      ra  = W'($urandom);
      sel = int'($urandom_range(0, 3));
      if (sel == 0)      rb = ra;
      else if (sel == 1) rb = ra ^ W'(1 << $urandom_range(0, W - 1));
      else               rb = W'($urandom);
      do_txn(ra, rb, 1'($urandom), int'($urandom_range(0, 2)),
             ($urandom_range(0, 7) == 0), 1'b0, lat, r);
      check("rnd_lat", 1, lat, exp_k(ra, rb, 2));
    end

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
